// File: rtl/stoch_pkg.sv
// Purpose : shared types/constants for the stochastic-computing datapath.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Build macro: SCALE_EN selects the scaled output width in out_w().
package stoch_pkg;

    // Window-counter FSM state, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default log2 fan-in of the upstream mux adder.
    localparam int LOGINUM_DEF = 4;

    // Width of the published count. In raw mode the fan-in term has no
    // effect; it is multiplied by zero so the argument is still consumed.
    function automatic int out_w(input int win_log, input int loginum);
`ifdef SCALE_EN
        return win_log + 1 + loginum;
`else
        return win_log + 1 + (0 * loginum);
`endif
    endfunction

endpackage

// File: rtl/sc_win_cnt.sv
// Purpose : WIN_LOG-bit enabled sample counter for one counting window.
// Latency : count updates on the edge after i_en; o_last_sample is combinational.
// Backpressure: none; counts every enabled cycle, i_clr has priority.
// Ports   : clk, rst_n (async, active low), i_clr (sync clear), i_en (count
//           enable), i_in_en (raw sample qualifier), o_win (current count),
//           o_last_sample (i_in_en while the counter is all-ones).
module sc_win_cnt #(
    parameter int WIN_LOG = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_in_en,
    output logic [WIN_LOG-1:0] o_win,
    output logic               o_last_sample
);

    logic [WIN_LOG-1:0] r_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (i_clr) begin
            r_win <= '0;
        end else if (i_en) begin
            // Wraps to zero naturally after the last sample of a window.
            r_win <= r_win + WIN_LOG'(1);
        end
    end

    assign o_win         = r_win;
    assign o_last_sample = i_in_en & (&r_win);

endmodule

// File: rtl/sc_bitstream_count.sv
// Purpose : counts ones of a stochastic bitstream over 2^WIN_LOG enabled samples.
// Latency : out_vld pulses the cycle after the last counted sample (>= 2^WIN_LOG+1 from start).
// Backpressure: none; in_en low stretches the window, abort cancels it.
// Ports   : clk, rst_n (async, active low), start, abort, in_en, in_bit in;
//           busy (window running), out_cnt (last count), out_vld (1-cycle pulse) out.
// Build macro: SCALE_EN shifts the count left by LOGINUM to undo the adder scaling.
module sc_bitstream_count
    import stoch_pkg::*;
#(
    parameter int WIN_LOG = 8,
    parameter int LOGINUM = LOGINUM_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                in_en,
    input  logic                                in_bit,
    output logic                                busy,
    output logic [out_w(WIN_LOG, LOGINUM)-1:0]  out_cnt,
    output logic                                out_vld
);

    localparam int OUT_W = out_w(WIN_LOG, LOGINUM);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIN_LOG:0]   r_acc;
    logic [OUT_W-1:0]   r_out_cnt;
    logic               r_out_vld;

    logic               w_run;
    logic               w_clr;
    logic               w_cnt_en;
    logic               w_last_raw;
    logic               w_last;
    logic [WIN_LOG:0]   w_sum;
    logic [WIN_LOG-1:0] w_win;

    assign w_run = (r_state == ST_RUN);

    // Clear on window launch (from IDLE or DONE) and on abort while running.
    assign w_clr = (start & ((r_state == ST_IDLE) | (r_state == ST_DONE)))
                 | (w_run & abort);

    assign w_cnt_en = w_run & in_en;

    sc_win_cnt #(
        .WIN_LOG (WIN_LOG)
    ) u_win_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_clr),
        .i_en          (w_cnt_en),
        .i_in_en       (in_en),
        .o_win         (w_win),
        .o_last_sample (w_last_raw)
    );

    // Abort beats a coincident last sample: no result is published.
    assign w_last = w_run & w_last_raw & ~abort;

    assign w_sum = r_acc + {{WIN_LOG{1'b0}}, in_bit};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_out_cnt <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_vld <= w_last;
            if (w_clr) begin
                r_acc <= '0;
            end else if (w_cnt_en) begin
                r_acc <= w_sum;
            end
            if (w_last) begin
`ifdef SCALE_EN
                r_out_cnt <= {w_sum, {LOGINUM{1'b0}}};
`else
                r_out_cnt <= w_sum;
`endif
            end
        end
    end

    assign busy    = w_run;
    assign out_cnt = r_out_cnt;
    assign out_vld = r_out_vld;

    // The window index is only consumed through last_sample here.
    logic w_unused_win;
    assign w_unused_win = ^w_win;

endmodule

// File: tb/tb_sc_bitstream_count.sv
// Purpose : directed self-checking bench for sc_bitstream_count at WIN_LOG=4.
// Latency : n/a.
// Backpressure: n/a.
module tb_sc_bitstream_count;
    import stoch_pkg::*;

    localparam int WIN_LOG = 4;
    localparam int LOGINUM = 4;
`ifdef SCALE_EN
    localparam int OUT_W_TB = WIN_LOG + 1 + LOGINUM;
`else
    localparam int OUT_W_TB = WIN_LOG + 1;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                in_en = 1'b0;
    logic                in_bit = 1'b0;
    logic                busy;
    logic [OUT_W_TB-1:0] out_cnt;
    logic                out_vld;

    int n_chk = 0;
    int n_pass = 0;

    sc_bitstream_count #(
        .WIN_LOG (WIN_LOG),
        .LOGINUM (LOGINUM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .in_en   (in_en),
        .in_bit  (in_bit),
        .busy    (busy),
        .out_cnt (out_cnt),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int scl(input int c);
`ifdef SCALE_EN
        return c << LOGINUM;
`else
        return c;
`endif
    endfunction

    // mode 0: all ones; 1: all zeros; 2: alternating bit, in_en low every
    // third cycle; 3: alternating bit, in_en always high.
    task automatic window(input int mode, input int exp_cnt, input int exp_cycles,
                          input string tag);
        logic early;
        early = 1'b0;
        start = 1'b1; in_en = 1'b0; in_bit = 1'b0;
        tick;
        start = 1'b0;
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_vld_low_at_start"}, out_vld, 0);
        for (int k = 0; k < exp_cycles; k++) begin
            case (mode)
                0:       begin in_en = 1'b1; in_bit = 1'b1; end
                1:       begin in_en = 1'b1; in_bit = 1'b0; end
                2:       begin in_en = (k % 3 != 2); in_bit = (k % 2 == 0); end
                default: begin in_en = 1'b1; in_bit = (k % 2 == 0); end
            endcase
            tick;
            if (k < exp_cycles - 1 && out_vld) early = 1'b1;
        end
        in_en = 1'b0; in_bit = 1'b0;
        chk({tag, "_no_early_vld"}, early, 0);
        chk({tag, "_vld"}, out_vld, 1);
        chk({tag, "_cnt"}, out_cnt, scl(exp_cnt));
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        logic seen;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_cnt", out_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // All ones: 16 samples, pulse 16 cycles after the start edge
        window(0, 16, 16, "ones");
        tick;
        chk("ones_vld_one_cycle", out_vld, 0);
        chk("ones_cnt_hold", out_cnt, scl(16));

        // Abort at sample 10
        start = 1'b1; tick; start = 1'b0;
        for (int k = 0; k < 9; k++) begin in_en = 1'b1; in_bit = 1'b1; tick; end
        abort = 1'b1; in_en = 1'b1; tick; abort = 1'b0;
        chk("abort10_busy", busy, 0);
        chk("abort10_vld", out_vld, 0);
        chk("abort10_cnt", out_cnt, scl(16));
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin tick; if (out_vld) seen = 1'b1; end
        in_en = 1'b0; in_bit = 1'b0;
        chk("abort10_idle_no_vld", seen, 0);

        // Zeros after abort: acc must have been cleared
        window(1, 0, 16, "zeros");
        tick;

        // Abort together with start, coincident with the 16th sample
        start = 1'b1; tick; start = 1'b0;
        for (int k = 0; k < 15; k++) begin in_en = 1'b1; in_bit = 1'b1; tick; end
        abort = 1'b1; start = 1'b1; in_en = 1'b1; in_bit = 1'b1; tick;
        abort = 1'b0; start = 1'b0; in_en = 1'b0; in_bit = 1'b0;
        chk("abort16_busy", busy, 0);
        chk("abort16_vld", out_vld, 0);
        chk("abort16_cnt", out_cnt, scl(0));
        tick;
        chk("abort16_vld_next", out_vld, 0);

        // Alternating bits with in_en low every third cycle: last sample at k=22
        window(2, 8, 23, "gapped");
        tick;

        // Back-to-back: start issued in DONE goes straight to RUN
        window(0, 16, 16, "b2b_a");
        window(3, 8, 16, "b2b_b");
        tick;
        chk("b2b_idle_busy", busy, 0);

        // Reset mid-window drops everything asynchronously
        start = 1'b1; tick; start = 1'b0;
        for (int k = 0; k < 5; k++) begin in_en = 1'b1; in_bit = 1'b1; tick; end
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cnt", out_cnt, 0);
        in_en = 1'b0; in_bit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Clean window after reset, then reset while out_vld is high
        window(0, 16, 16, "post_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("rstdone_vld", out_vld, 0);
        chk("rstdone_cnt", out_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("rstdone_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
